// File: rtl/col_parity_pkg.sv
// col_parity_pkg: shared types and helpers for the column-parity scheduler.
//   state_t   : scheduler FSM states (IDLE, ACCUM, DONE)
//   cnt_w(n)  : counter/index width, max(1, $clog2(n))
//   ERR_CNT_W : width of the optional nonzero-syndrome counter
package col_parity_pkg;

    localparam int unsigned ERR_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int unsigned cnt_w(input int unsigned n);
        if (n <= 32'd1) return 32'd1;
        return unsigned'($clog2(n));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first request at or above ptr with wrap.
//   req     in  NREQ : request vector
//   ptr     in  IDW  : search start index (always < NREQ)
//   gnt     out NREQ : one-hot grant (zero when no request)
//   gnt_idx out IDW  : encoded grant index
//   any     out 1    : at least one request present
module rr_arbiter
    import col_parity_pkg::*;
#(
    parameter  int unsigned NREQ = 2,
    localparam int unsigned IDW  = cnt_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any
);

    logic           hi_found;
    logic [IDW-1:0] hi_idx;
    logic [IDW-1:0] lo_idx;

    assign any = |req;

    // Downward scan so the lowest matching index wins in each half.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            if (req[k]) begin
                if (32'(k) >= 32'(ptr)) begin
                    hi_found = 1'b1;
                    hi_idx   = IDW'(k);
                end else begin
                    lo_idx   = IDW'(k);
                end
            end
        end
        gnt_idx = hi_found ? hi_idx : lo_idx;
        gnt     = any ? (NREQ'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/col_parity_sched.sv
// col_parity_sched: round-robin shared column-XOR reducer for NREQ requesters.
// Each granted frame of NROWS rows is XOR-folded column-wise and the syndrome is
// presented on a valid/ready port tagged with the owning requester.
//   clk, rst_n           : clock, async active-low reset
//   req_valid/req_data   : per-requester row stream (requester k at [k*WIDTH +: WIDTH])
//   req_ready            : per-requester row accept, one-hot or zero (registered)
//   par_valid/par_data/par_id/par_ready : syndrome output handshake
// Optional (macro COL_PARITY_CHECK_EN):
//   par_zero : syndrome is all-zero, valid with par_valid
//   err_cnt  : saturating count of accepted nonzero syndromes
module col_parity_sched
    import col_parity_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned NROWS = 4,
    parameter  int unsigned NREQ  = 2,
    localparam int unsigned IDW   = cnt_w(NREQ),
    localparam int unsigned CW    = cnt_w(NROWS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  par_valid,
    output logic [WIDTH-1:0]      par_data,
    output logic [IDW-1:0]        par_id,
    input  logic                  par_ready
`ifdef COL_PARITY_CHECK_EN
    ,
    output logic [ERR_CNT_W-1:0]  err_cnt,
    output logic                  par_zero
`endif
);

    state_t           state, state_d;
    logic [IDW-1:0]   grant, grant_d;
    logic [IDW-1:0]   rr_ptr, rr_ptr_d;
    logic [IDW-1:0]   par_id_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [WIDTH-1:0] acc, acc_d;
    logic [WIDTH-1:0] par_data_d;
    logic [WIDTH-1:0] row;
    logic             par_valid_d;
    logic [NREQ-1:0]  req_ready_d;
    logic [NREQ-1:0]  arb_gnt;
    logic [IDW-1:0]   arb_idx;
    logic             arb_any;
    logic             hs;
    logic             last;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    // Row of the currently granted requester.
    always_comb begin
        row = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            if (grant == IDW'(k)) row = req_data[k*WIDTH +: WIDTH];
        end
    end

    // req_ready is one-hot on the grant in ACCUM, so this is the grant handshake.
    assign hs   = |(req_valid & req_ready);
    assign last = hs && (cnt == CW'(NROWS - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Next-state and next-register values.
    always_comb begin
        state_d     = state;
        grant_d     = grant;
        rr_ptr_d    = rr_ptr;
        cnt_d       = cnt;
        acc_d       = acc;
        par_valid_d = par_valid;
        par_data_d  = par_data;
        par_id_d    = par_id;
        req_ready_d = req_ready;
        unique case (state)
            IDLE: begin
                if (arb_any) begin
                    grant_d     = arb_idx;
                    req_ready_d = arb_gnt;
                    cnt_d       = '0;
                    acc_d       = '0;
                    state_d     = ACCUM;
                end
            end
            ACCUM: begin
                if (hs) begin
                    acc_d = acc ^ row;
                    cnt_d = cnt + CW'(1);
                    if (last) begin
                        par_data_d  = acc ^ row;
                        par_id_d    = grant;
                        par_valid_d = 1'b1;
                        req_ready_d = '0;
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                if (par_ready) begin
                    par_valid_d = 1'b0;
                    rr_ptr_d    = (32'(grant) == NREQ - 1) ? '0 : grant + IDW'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant     <= '0;
            rr_ptr    <= '0;
            cnt       <= '0;
            acc       <= '0;
            par_valid <= 1'b0;
            par_data  <= '0;
            par_id    <= '0;
            req_ready <= '0;
        end else begin
            grant     <= grant_d;
            rr_ptr    <= rr_ptr_d;
            cnt       <= cnt_d;
            acc       <= acc_d;
            par_valid <= par_valid_d;
            par_data  <= par_data_d;
            par_id    <= par_id_d;
            req_ready <= req_ready_d;
        end
    end

`ifdef COL_PARITY_CHECK_EN
    // Zero flag captured with the syndrome; counter saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_zero <= 1'b1;
            err_cnt  <= '0;
        end else begin
            if (state == ACCUM && last) par_zero <= ((acc ^ row) == '0);
            if (par_valid && par_ready && !par_zero && err_cnt != '1)
                err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_col_parity_sched.sv
// tb_col_parity_sched: directed + randomized bench for col_parity_sched against a
// frame-level reference (per-requester row queues and expected-syndrome queues).
module tb_col_parity_sched;

    localparam int WIDTH = 8;
    localparam int NROWS = 4;
    localparam int NREQ  = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic [NREQ-1:0]       req_ready;
    logic                  par_valid;
    logic [WIDTH-1:0]      par_data;
    logic [0:0]            par_id;
    logic                  par_ready = 1'b0;
`ifdef COL_PARITY_CHECK_EN
    logic [15:0]           err_cnt;
    logic                  par_zero;
    int                    err_model;
`endif

    col_parity_sched #(.WIDTH(WIDTH), .NROWS(NROWS), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .par_valid (par_valid),
        .par_data  (par_data),
        .par_id    (par_id),
        .par_ready (par_ready)
`ifdef COL_PARITY_CHECK_EN
        ,
        .err_cnt   (err_cnt),
        .par_zero  (par_zero)
`endif
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] rowq [NREQ][$];
    logic [WIDTH-1:0] expq [NREQ][$];
    int               hsn [NREQ];
    int               vprob [NREQ];
    int               pr_prob;
    int               owner;
    bit               pending_pv;
    bit               prev_hold;
    logic [WIDTH-1:0] prev_data;
    logic [0:0]       prev_id;
    int               served [$];
    int               n_cmp = 0;
    int               n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NREQ; k++) begin
            rowq[k].delete();
            expq[k].delete();
            hsn[k] = 0;
        end
        owner      = -1;
        pending_pv = 1'b0;
        prev_hold  = 1'b0;
        served.delete();
`ifdef COL_PARITY_CHECK_EN
        err_model  = 0;
`endif
    endtask

    // Queue one frame; row i is rows[i*8 +: 8]. Expected syndrome is the XOR of all rows.
    task automatic add_frame(input int k, input logic [31:0] rows);
        logic [WIDTH-1:0] syn;
        syn = '0;
        for (int i = 0; i < NROWS; i++) begin
            rowq[k].push_back(rows[i*WIDTH +: WIDTH]);
            syn = syn ^ rows[i*WIDTH +: WIDTH];
        end
        expq[k].push_back(syn);
    endtask

    function automatic bit all_empty();
        for (int k = 0; k < NREQ; k++)
            if (rowq[k].size() != 0 || expq[k].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // One clock: check outputs, drive inputs for the next edge, record handshakes.
    task automatic cycle();
        logic [WIDTH-1:0] want;
        @(negedge clk);
        if (pending_pv) check("pv_after_last_row", 32'(par_valid), 1);
        pending_pv = 1'b0;
        if (prev_hold) begin
            check("hold_valid", 32'(par_valid), 1);
            check("hold_data", 32'(par_data), 32'(prev_data));
            check("hold_id", 32'(par_id), 32'(prev_id));
        end
        check("ready_onehot0", 32'($onehot0(req_ready)), 1);
        check("ready_while_valid", 32'(par_valid && (req_ready != '0)), 0);
`ifdef COL_PARITY_CHECK_EN
        check("err_cnt", 32'(err_cnt), 32'(err_model));
`endif
        for (int k = 0; k < NREQ; k++) begin
            if (rowq[k].size() != 0 && int'($urandom_range(99)) < vprob[k]) begin
                req_valid[k] = 1'b1;
                req_data[k*WIDTH +: WIDTH] = rowq[k][0];
            end else begin
                req_valid[k] = 1'b0;
                req_data[k*WIDTH +: WIDTH] = WIDTH'($urandom);
            end
        end
        par_ready = (int'($urandom_range(99)) < pr_prob);
        for (int k = 0; k < NREQ; k++) begin
            if (req_valid[k] && req_ready[k]) begin
                if (owner >= 0) check("grant_lock", 32'(k), 32'(owner));
                owner = k;
                void'(rowq[k].pop_front());
                hsn[k]++;
                if (hsn[k] == NROWS) begin
                    hsn[k]     = 0;
                    owner      = -1;
                    pending_pv = 1'b1;
                end
            end
        end
        if (par_valid && par_ready) begin
            check("syndrome_expected", 32'(expq[par_id].size() != 0), 1);
            if (expq[par_id].size() != 0) begin
                want = expq[par_id].pop_front();
                check("par_data", 32'(par_data), 32'(want));
`ifdef COL_PARITY_CHECK_EN
                check("par_zero", 32'(par_zero), 32'(want == '0));
                if (want != '0 && err_model < 16'hFFFF) err_model++;
`endif
                served.push_back(int'(par_id));
            end
        end
        prev_hold = par_valid && !par_ready;
        prev_data = par_data;
        prev_id   = par_id;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (!all_empty() && n < budget) begin
            cycle();
            n++;
        end
        check(tag, 32'(all_empty()), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        par_ready = 1'b0;
        #1;
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_par_valid", 32'(par_valid), 0);
        check("rst_par_data", 32'(par_data), 0);
        check("rst_par_id", 32'(par_id), 0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        vprob[0] = 100;
        vprob[1] = 100;
        pr_prob  = 100;
        model_clear();

        // Reset state.
        do_reset();

        // Single frame from requester 0.
        add_frame(0, {8'h08, 8'h04, 8'h02, 8'h01});
        drain("t1_drain", 40);
        check("t1_count", 32'(served.size()), 1);
        if (served.size() == 1) check("t1_id", 32'(served[0]), 0);

        // Both requesters valid from reset; requester 0 wins first.
        do_reset();
        add_frame(0, {8'hFF, 8'hFF, 8'hFF, 8'hFF});
        add_frame(1, {8'h00, 8'h00, 8'h55, 8'hAA});
        drain("t2_drain", 60);
        check("t2_count", 32'(served.size()), 2);
        if (served.size() == 2) begin
            check("t2_first", 32'(served[0]), 0);
            check("t2_second", 32'(served[1]), 1);
        end

        // Pointer moves past the last winner: after req0 alone, req1 goes first.
        served.delete();
        add_frame(0, $urandom);
        drain("t2c_solo", 40);
        add_frame(0, $urandom);
        add_frame(1, $urandom);
        drain("t2c_both", 60);
        check("t2c_count", 32'(served.size()), 3);
        if (served.size() == 3) begin
            check("t2c_first", 32'(served[1]), 1);
            check("t2c_second", 32'(served[2]), 0);
        end

        // Consumer backpressure for 5 cycles while another requester waits.
        pr_prob = 0;
        add_frame(0, $urandom);
        add_frame(1, $urandom);
        n = 0;
        while (!par_valid && n < 50) begin
            cycle();
            n++;
        end
        check("t3_valid_seen", 32'(par_valid), 1);
        for (int i = 0; i < 5; i++) cycle();
        pr_prob = 100;
        drain("t3_drain", 60);

        // Granted requester stalls for 3 cycles after its second row.
        add_frame(0, {8'h88, 8'h44, 8'h22, 8'h11});
        n = 0;
        while (rowq[0].size() > 2 && n < 40) begin
            cycle();
            n++;
        end
        check("t4_two_rows", 32'(rowq[0].size()), 2);
        vprob[0] = 0;
        for (int i = 0; i < 3; i++) cycle();
        vprob[0] = 100;
        drain("t4_drain", 40);

        // Reset in mid-frame discards the partial frame.
        add_frame(0, $urandom);
        n = 0;
        while (rowq[0].size() > 2 && n < 40) begin
            cycle();
            n++;
        end
        do_reset();
        add_frame(0, {8'h00, 8'h00, 8'h00, 8'h03});
        drain("t5_drain", 40);
        check("t5_count", 32'(served.size()), 1);

`ifdef COL_PARITY_CHECK_EN
        // Zero / nonzero syndromes and the error counter.
        do_reset();
        add_frame(0, {8'h00, 8'h00, 8'h00, 8'h00});
        add_frame(0, {8'h00, 8'h00, 8'h00, 8'h0F});
        add_frame(0, {8'h00, 8'h00, 8'h00, 8'h01});
        drain("t6_drain", 80);
        cycle();
        check("t6_err_cnt_final", 32'(err_cnt), 2);
`endif

        // Randomized traffic with random valid and ready duty cycles.
        for (int f = 0; f < 40; f++) begin
            add_frame(int'($urandom_range(NREQ - 1)), $urandom);
            if (f % 8 == 0) begin
                vprob[0] = int'($urandom_range(100, 30));
                vprob[1] = int'($urandom_range(100, 30));
                pr_prob  = int'($urandom_range(100, 30));
            end
        end
        drain("t7_drain", 6000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
